// File: rtl/sdram_aref_if.sv
// Refresh-controller <-> arbiter bundle; master = sdram_aref, slave = arbiter side.
interface sdram_aref_if;
  logic        i_init_done;
  logic        i_aref_en;
  logic        o_aref_req;
  logic [3:0]  o_aref_cmd;
  logic [1:0]  o_aref_ba;
  logic [12:0] o_aref_addr;
  logic        o_aref_busy;
  logic        o_aref_end;
  logic        o_aref_ovf;

  modport master (
    input  i_init_done, i_aref_en,
    output o_aref_req, o_aref_cmd, o_aref_ba, o_aref_addr,
           o_aref_busy, o_aref_end, o_aref_ovf
  );

  modport slave (
    output i_init_done, i_aref_en,
    input  o_aref_req, o_aref_cmd, o_aref_ba, o_aref_addr,
           o_aref_busy, o_aref_end, o_aref_ovf
  );
endinterface

// File: rtl/sdram_aref.sv
// Auto-refresh sequencer: periodic request, then PRECHARGE-ALL + AREF_NUM AUTO REFRESH; grant-to-command 1 cycle.
// Request is held until granted while the timer keeps running; AREF_OVERRUN_CHK_EN adds a sticky missed-period flag.
module sdram_aref #(
  parameter int REF_PERIOD_CYC = 750,
  parameter int TRP_CYC        = 2,
  parameter int TRC_CYC        = 7,
  parameter int AREF_NUM       = 2
) (
  input  logic         i_sysclk,
  input  logic         i_sysrst,
  sdram_aref_if.master bus
);
  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [3:0]  CMD_PCHG  = 4'b0010;
  localparam logic [3:0]  CMD_AREF  = 4'b0001;
  localparam logic [1:0]  BA_IDLE   = 2'b11;
  localparam logic [12:0] ADDR_IDLE = 13'h1FFF;
  localparam logic [12:0] ADDR_PALL = 13'h0400;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PCHG = 3'd1;
  localparam logic [2:0] ST_TRP  = 3'd2;
  localparam logic [2:0] ST_AREF = 3'd3;
  localparam logic [2:0] ST_TRF  = 3'd4;
  localparam logic [2:0] ST_END  = 3'd5;

  localparam int TMR_W   = (REF_PERIOD_CYC > 1) ? $clog2(REF_PERIOD_CYC) : 1;
  localparam int DLY_MAX = (TRP_CYC > TRC_CYC) ? TRP_CYC : TRC_CYC;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int REF_W   = (AREF_NUM > 0) ? $clog2(AREF_NUM + 1) : 1;

  logic [2:0]       state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [DLY_W-1:0] dly;
  logic [REF_W-1:0] ref_cnt;
  logic             expiry, accept;
  logic             aref_req, aref_ovf, aref_busy, aref_end;
  logic [3:0]       cmd_q;
  logic [1:0]       ba_q;
  logic [12:0]      addr_q;

  assign expiry = bus.i_init_done && (tmr == TMR_W'(REF_PERIOD_CYC - 1));
  assign accept = bus.i_aref_en && aref_req && (state == ST_IDLE);

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst || !bus.i_init_done || expiry) tmr <= '0;
    else                                        tmr <= tmr + TMR_W'(1);
  end

  // Expiry wins over acceptance so a period landing on the grant edge is not lost.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst || !bus.i_init_done) aref_req <= 1'b0;
    else if (expiry)                  aref_req <= 1'b1;
    else if (accept)                  aref_req <= 1'b0;
  end

`ifdef AREF_OVERRUN_CHK_EN
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst)                 aref_ovf <= 1'b0;
    else if (expiry && aref_req)  aref_ovf <= 1'b1;
  end
`else
  assign aref_ovf = 1'b0;
`endif

  // TRP_CYC and TRC_CYC are expected to be at least 1.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_PCHG;
      ST_PCHG: state_nxt = ST_TRP;
      ST_TRP:  if (dly == DLY_W'(TRP_CYC - 1)) state_nxt = ST_AREF;
      ST_AREF: state_nxt = ST_TRF;
      ST_TRF:  if (dly == DLY_W'(TRC_CYC - 1))
                 state_nxt = (ref_cnt == REF_W'(AREF_NUM)) ? ST_END : ST_AREF;
      ST_END:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state   <= ST_IDLE;
      dly     <= '0;
      ref_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == ST_IDLE) dly <= '0;
      else                                        dly <= dly + DLY_W'(1);
      if (state == ST_IDLE)      ref_cnt <= '0;
      else if (state == ST_AREF) ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // Outputs are decoded from the state being entered so they line up with it.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      cmd_q     <= CMD_NOP;
      ba_q      <= BA_IDLE;
      addr_q    <= ADDR_IDLE;
      aref_busy <= 1'b0;
      aref_end  <= 1'b0;
    end else begin
      cmd_q     <= (state_nxt == ST_PCHG) ? CMD_PCHG :
                   (state_nxt == ST_AREF) ? CMD_AREF : CMD_NOP;
      ba_q      <= BA_IDLE;
      addr_q    <= (state_nxt == ST_PCHG) ? ADDR_PALL : ADDR_IDLE;
      aref_busy <= (state_nxt != ST_IDLE);
      aref_end  <= (state_nxt == ST_END);
    end
  end

  assign bus.o_aref_req  = aref_req;
  assign bus.o_aref_cmd  = cmd_q;
  assign bus.o_aref_ba   = ba_q;
  assign bus.o_aref_addr = addr_q;
  assign bus.o_aref_busy = aref_busy;
  assign bus.o_aref_end  = aref_end;
  assign bus.o_aref_ovf  = aref_ovf;
endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: default instance plus a short-period AREF_NUM=4/TRC_CYC=3 instance, checked against a schedule model.
module tb_sdram_aref;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_aref_if bus0();
  sdram_aref_if bus1();

  sdram_aref dut0 (.i_sysclk(clk), .i_sysrst(rst), .bus(bus0));
  sdram_aref #(.REF_PERIOD_CYC(60), .TRP_CYC(2), .TRC_CYC(3), .AREF_NUM(4))
    dut1 (.i_sysclk(clk), .i_sysrst(rst), .bus(bus1));

  localparam int PER_T [2] = '{750, 60};
  localparam int TRP_T [2] = '{2, 2};
  localparam int TRC_T [2] = '{7, 3};
  localparam int NUM_T [2] = '{2, 4};
`ifdef AREF_OVERRUN_CHK_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: edges with init high, request flag, overrun flag, last acceptance edge.
  int edge_k = 0;
  int hi   [2];
  bit mreq [2];
  bit movf [2];
  bit act  [2];
  int acc  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int seq_len(input int u);
    return 2 + TRP_T[u] + NUM_T[u] * (1 + TRC_T[u]);
  endfunction

  task automatic model_step(input bit r, input bit init, input bit en);
    bit idle, accept, expiry;
    edge_k++;
    for (int u = 0; u < 2; u++) begin
      if (r) begin
        hi[u] = 0; mreq[u] = 0; movf[u] = 0; act[u] = 0;
      end else begin
        idle   = !act[u] || (edge_k - acc[u] > seq_len(u));
        accept = en && mreq[u] && idle;
        expiry = init && ((hi[u] + 1) % PER_T[u] == 0);
        if (expiry && mreq[u]) movf[u] = 1;
        hi[u]   = init ? hi[u] + 1 : 0;
        mreq[u] = !init ? 1'b0 : expiry ? 1'b1 : accept ? 1'b0 : mreq[u];
        if (accept) begin act[u] = 1; acc[u] = edge_k; end
      end
    end
  endtask

  task automatic check_one(input int u, input logic [3:0] cmd, input logic [1:0] ba,
                           input logic [12:0] addr, input logic req, input logic busy,
                           input logic endp, input logic ovf);
    int c, e, p, s;
    logic [3:0] ecmd;
    bit ebusy;
    e = seq_len(u);
    p = TRP_T[u];
    s = 1 + TRC_T[u];
    c = act[u] ? edge_k - acc[u] + 1 : 0;
    ebusy = act[u] && c >= 1 && c <= e;
    ecmd = 4'b0111;
    if (ebusy && c == 1) ecmd = 4'b0010;
    else if (ebusy && c >= 2 + p && c < e && (c - 2 - p) % s == 0) ecmd = 4'b0001;
    chk($sformatf("d%0d cmd", u),  cmd,  ecmd);
    chk($sformatf("d%0d ba", u),   ba,   2'b11);
    chk($sformatf("d%0d addr", u), addr, (ebusy && c == 1) ? 13'h0400 : 13'h1FFF);
    chk($sformatf("d%0d req", u),  req,  mreq[u]);
    chk($sformatf("d%0d busy", u), busy, ebusy);
    chk($sformatf("d%0d end", u),  endp, ebusy && c == e);
    chk($sformatf("d%0d ovf", u),  ovf,  OVF_ON && movf[u]);
  endtask

  task automatic tick(input bit r, input bit init, input bit en);
    rst = r;
    bus0.i_init_done = init; bus1.i_init_done = init;
    bus0.i_aref_en   = en;   bus1.i_aref_en   = en;
    @(posedge clk);
    model_step(r, init, en);
    #1;
    check_one(0, bus0.o_aref_cmd, bus0.o_aref_ba, bus0.o_aref_addr, bus0.o_aref_req,
              bus0.o_aref_busy, bus0.o_aref_end, bus0.o_aref_ovf);
    check_one(1, bus1.o_aref_cmd, bus1.o_aref_ba, bus1.o_aref_addr, bus1.o_aref_req,
              bus1.o_aref_busy, bus1.o_aref_end, bus1.o_aref_ovf);
  endtask

  task automatic run_until_req(input int budget);
    int n = 0;
    while (!bus0.o_aref_req && n < budget) begin tick(0, 1, 0); n++; end
    chk("req wait", bus0.o_aref_req, 1'b1);
  endtask

  // One-cycle grant, then 24 more cycles; AREF positions and END cycle versus the spec formula.
  task automatic grant_seq();
    logic [31:0] m0, m1, e0, e1;
    int end0, end1, busy0, busy1;
    m0 = '0; m1 = '0; end0 = 0; end1 = 0; busy0 = 0; busy1 = 0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      tick(0, 1, cyc == 1);
      if (bus0.o_aref_cmd == 4'b0001) m0[cyc] = 1'b1;
      if (bus1.o_aref_cmd == 4'b0001) m1[cyc] = 1'b1;
      if (bus0.o_aref_end) end0 = cyc;
      if (bus1.o_aref_end) end1 = cyc;
      busy0 += int'(bus0.o_aref_busy);
      busy1 += int'(bus1.o_aref_busy);
    end
    e0 = '0; e1 = '0;
    for (int k = 0; k < NUM_T[0]; k++) e0[2 + TRP_T[0] + k * (1 + TRC_T[0])] = 1'b1;
    for (int k = 0; k < NUM_T[1]; k++) e1[2 + TRP_T[1] + k * (1 + TRC_T[1])] = 1'b1;
    chk("d0 aref cycles", m0, e0);
    chk("d1 aref cycles", m1, e1);
    chk("d0 end cycle", end0, seq_len(0));
    chk("d1 end cycle", end1, seq_len(1));
    chk("d0 busy cycles", busy0, seq_len(0));
    chk("d1 busy cycles", busy1, seq_len(1));
  endtask

  initial begin
    int n, lowcnt;
    bit r, init, en;

    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    chk("reset cmd", bus0.o_aref_cmd, 4'b0111);
    chk("reset addr", bus0.o_aref_addr, 13'h1FFF);
    for (int i = 0; i < 2000; i++) tick(0, 0, 0);

    n = 0;
    do begin tick(0, 1, 0); n++; end while (!bus0.o_aref_req && n < 900);
    chk("first req latency", n, 750);
    for (int i = 0; i < 20; i++) tick(0, 1, 0);
    chk("req held", bus0.o_aref_req, 1'b1);

    grant_seq();

    // Grant 760 cycles after the request: one period missed.
    run_until_req(800);
    for (int i = 0; i < 759; i++) tick(0, 1, 0);
    grant_seq();
    chk("late ovf", bus0.o_aref_ovf, OVF_ON);

    // Grant 740 cycles after the request: expiry falls inside the sequence.
    run_until_req(800);
    for (int i = 0; i < 739; i++) tick(0, 1, 0);
    grant_seq();
    chk("pending after seq", bus0.o_aref_req, 1'b1);

    // Grant on the expiry edge itself.
    n = 0;
    while ((hi[0] + 1) % PER_T[0] != 0 && n < 800) begin tick(0, 1, 0); n++; end
    grant_seq();
    chk("pending after coincident", bus0.o_aref_req, 1'b1);

    // Reset six cycles into a sequence.
    run_until_req(800);
    tick(0, 1, 1);
    for (int i = 0; i < 5; i++) tick(0, 1, 0);
    tick(1, 1, 0);
    chk("rst mid cmd", bus0.o_aref_cmd, 4'b0111);
    chk("rst mid busy", bus0.o_aref_busy, 1'b0);
    n = 0;
    do begin tick(0, 1, 0); n++; end while (!bus0.o_aref_req && n < 900);
    chk("req after rst", n, 750);

    lowcnt = 0;
    for (int i = 0; i < 6000; i++) begin
      r = ($urandom % 4000) == 0;
      if (lowcnt == 0 && ($urandom % 1500) == 0) lowcnt = $urandom_range(1, 20);
      init = (lowcnt == 0);
      if (lowcnt > 0) lowcnt--;
      en = ($urandom % 6) == 0;
      tick(r, init, en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
